// File: rtl/riscv_pipe_pkg.sv
// Shared types for the pipelined core's hazard/control unit.
// Stage records, forwarding selects and branch-stage encodings.
package riscv_pipe_pkg;

  // rd is held zero-extended so the record type is independent of REG_AW
  localparam int RD_W_MAX = 8;

  localparam int BR_EX  = 2;
  localparam int BR_MEM = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                regwrite;
    logic                memread;
  } stage_rec_t;

  function automatic logic rec_hit(
    input stage_rec_t          r,
    input logic [RD_W_MAX-1:0] rs,
    input logic                use_rs
  );
    return r.valid & r.regwrite & use_rs &
           (r.rd == rs) & (rs != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
// Holds at all ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline control for the 5-stage core.
// Tracks EX/MEM/WB shadow records; drives stall, bubble, flush, fwd.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 2,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_regwrite,
  input  logic              i_id_memread,
  input  logic              i_br_taken,
  input  logic              i_mem_busy,
  output logic              o_stall_pc,
  output logic              o_bubble_ex,
  output logic              o_flush,
  output logic              o_freeze,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_ex_valid,
  output logic              o_mem_valid,
  output logic              o_wb_valid,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  stage_rec_t ex_q, mem_q, wb_q, ex_d;
  fwd_sel_t   fwd_a_q, fwd_b_q;
  fwd_sel_t   fwd_a_d, fwd_b_d;

  logic [RD_W_MAX-1:0] rs1, rs2, rdi;
  logic ex_a, ex_b, mem_a, mem_b;
  logic br_valid, raw_hz, flush, hazard, ex_in_v;

  assign rs1 = RD_W_MAX'(i_id_rs1);
  assign rs2 = RD_W_MAX'(i_id_rs2);
  assign rdi = RD_W_MAX'(i_id_rd);

  assign ex_a  = rec_hit(ex_q,  rs1, i_id_use_rs1);
  assign ex_b  = rec_hit(ex_q,  rs2, i_id_use_rs2);
  assign mem_a = rec_hit(mem_q, rs1, i_id_use_rs1);
  assign mem_b = rec_hit(mem_q, rs2, i_id_use_rs2);

  assign br_valid = (BR_STAGE == BR_MEM) ? mem_q.valid
                                         : ex_q.valid;

  // Without forwarding, anything not yet in WB must be waited out
  assign raw_hz = (FWD_EN != 0)
                ? ((ex_a | ex_b) & ex_q.memread)
                : (ex_a | ex_b | mem_a | mem_b);

  assign flush   = ~i_mem_busy & i_br_taken & br_valid;
  assign hazard  = ~i_mem_busy & ~flush & i_id_valid & raw_hz;
  assign ex_in_v = i_id_valid & ~flush & ~hazard;

  function automatic fwd_sel_t pick(input logic e, input logic m);
    fwd_sel_t s;
    s = FWD_RF;
    priority case (1'b1)
      e:       s = FWD_MEM;
      m:       s = FWD_WB;
      default: s = FWD_RF;
    endcase
    return s;
  endfunction

  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if ((FWD_EN != 0) && ex_in_v) begin
      fwd_a_d = pick(ex_a, mem_a);
      fwd_b_d = pick(ex_b, mem_b);
    end
  end

  always_comb begin
    ex_d          = '0;
    ex_d.valid    = ex_in_v;
    ex_d.rd       = rdi;
    ex_d.regwrite = i_id_regwrite;
    ex_d.memread  = i_id_memread;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!i_mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (flush && (BR_STAGE == BR_MEM)) begin
        mem_q.valid <= 1'b0;
      end
      ex_q    <= ex_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .inc   (hazard),
    .cnt   (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .inc   (flush),
    .cnt   (o_flush_cnt)
  );

  assign o_stall_pc  = hazard;
  assign o_bubble_ex = hazard;
  assign o_flush     = flush;
  assign o_freeze    = i_mem_busy;
  assign o_fwd_a     = fwd_a_q;
  assign o_fwd_b     = fwd_b_q;
  assign o_ex_valid  = ex_q.valid;
  assign o_mem_valid = mem_q.valid;
  assign o_wb_valid  = wb_q.valid;

  // WB is tracked for visibility only; its payload has no consumer
  logic unused_rec;
  assign unused_rec = ^{mem_q.memread, wb_q.rd,
                        wb_q.regwrite, wb_q.memread};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations driven in lockstep.
// Directed scenarios followed by random traffic against a pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int BRS[3]  = '{2, 3, 2};
  localparam int FWE[3]  = '{1, 1, 0};
  localparam int CMAX[3] = '{65535, 65535, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, idv, u1, u2, rw, mr, br, busy;
  logic [4:0] rs1, rs2, rd;

  logic        stl[3], bub[3], flu[3], frz[3];
  logic        exv[3], memv[3], wbv[3];
  logic [1:0]  fa[3], fb[3];
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [1:0]  sc2, fc2;
  int          sc[3], fc[3];

  assign sc[0] = int'(sc0);
  assign sc[1] = int'(sc1);
  assign sc[2] = int'(sc2);
  assign fc[0] = int'(fc0);
  assign fc[1] = int'(fc1);
  assign fc[2] = int'(fc2);

  pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(2), .FWD_EN(1), .CNT_W(16)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(idv),
    .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(u1), .i_id_use_rs2(u2), .i_id_rd(rd),
    .i_id_regwrite(rw), .i_id_memread(mr),
    .i_br_taken(br), .i_mem_busy(busy),
    .o_stall_pc(stl[0]), .o_bubble_ex(bub[0]), .o_flush(flu[0]),
    .o_freeze(frz[0]), .o_fwd_a(fa[0]), .o_fwd_b(fb[0]),
    .o_ex_valid(exv[0]), .o_mem_valid(memv[0]), .o_wb_valid(wbv[0]),
    .o_stall_cnt(sc0), .o_flush_cnt(fc0));

  pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(3), .FWD_EN(1), .CNT_W(16)) u1i (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(idv),
    .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(u1), .i_id_use_rs2(u2), .i_id_rd(rd),
    .i_id_regwrite(rw), .i_id_memread(mr),
    .i_br_taken(br), .i_mem_busy(busy),
    .o_stall_pc(stl[1]), .o_bubble_ex(bub[1]), .o_flush(flu[1]),
    .o_freeze(frz[1]), .o_fwd_a(fa[1]), .o_fwd_b(fb[1]),
    .o_ex_valid(exv[1]), .o_mem_valid(memv[1]), .o_wb_valid(wbv[1]),
    .o_stall_cnt(sc1), .o_flush_cnt(fc1));

  pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(2), .FWD_EN(0), .CNT_W(2)) u2i (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(idv),
    .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(u1), .i_id_use_rs2(u2), .i_id_rd(rd),
    .i_id_regwrite(rw), .i_id_memread(mr),
    .i_br_taken(br), .i_mem_busy(busy),
    .o_stall_pc(stl[2]), .o_bubble_ex(bub[2]), .o_flush(flu[2]),
    .o_freeze(frz[2]), .o_fwd_a(fa[2]), .o_fwd_b(fb[2]),
    .o_ex_valid(exv[2]), .o_mem_valid(memv[2]), .o_wb_valid(wbv[2]),
    .o_stall_cnt(sc2), .o_flush_cnt(fc2));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pl[c][k] is the instruction k stages past ID (0=EX,1=MEM,2=WB)
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } mrec_t;

  mrec_t pl[3][3];
  int    mfa[3], mfb[3], msc[3], mfc[3];
  bit    m_stall[3], m_flush[3];

  function automatic bit hit(mrec_t r, int rs, bit u);
    return r.v && r.rw && (r.rd == rs) && (rs != 0) && u;
  endfunction

  function automatic bit dep(int c, int k);
    return hit(pl[c][k], int'(rs1), u1) || hit(pl[c][k], int'(rs2), u2);
  endfunction

  function automatic int src(int c, int rs, bit u);
    if (hit(pl[c][0], rs, u)) return 1;
    if (hit(pl[c][1], rs, u)) return 2;
    return 0;
  endfunction

  task automatic model_comb();
    for (int c = 0; c < 3; c++) begin
      bit older_ok, need;
      older_ok   = (BRS[c] == 3) ? pl[c][1].v : pl[c][0].v;
      m_flush[c] = !busy && br && older_ok;
      if (FWE[c] != 0) need = dep(c, 0) && pl[c][0].mr;
      else             need = dep(c, 0) || dep(c, 1);
      m_stall[c] = !busy && !m_flush[c] && idv && need;
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < 3; c++) begin
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) pl[c][k] = '{0, 0, 0, 0};
        mfa[c] = 0; mfb[c] = 0; msc[c] = 0; mfc[c] = 0;
      end else if (!busy) begin
        bit nv;
        nv = idv && !m_flush[c] && !m_stall[c];
        mfa[c] = (FWE[c] != 0 && nv) ? src(c, int'(rs1), u1) : 0;
        mfb[c] = (FWE[c] != 0 && nv) ? src(c, int'(rs2), u2) : 0;
        pl[c][2] = pl[c][1];
        pl[c][1] = pl[c][0];
        if (m_flush[c] && BRS[c] == 3) pl[c][1].v = 0;
        pl[c][0] = '{nv, int'(rd), rw, mr};
        if (m_stall[c] && msc[c] < CMAX[c]) msc[c]++;
        if (m_flush[c] && mfc[c] < CMAX[c]) mfc[c]++;
      end
    end
  endtask

  task automatic tick();
    #1;
    model_comb();
    if (chk_en) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("stall%0d", c), stl[c], m_stall[c]);
        chk($sformatf("bubble%0d", c), bub[c], m_stall[c]);
        chk($sformatf("flush%0d", c), flu[c], m_flush[c]);
        chk($sformatf("freeze%0d", c), frz[c], busy);
        chk($sformatf("exv%0d", c), exv[c], pl[c][0].v);
        chk($sformatf("memv%0d", c), memv[c], pl[c][1].v);
        chk($sformatf("wbv%0d", c), wbv[c], pl[c][2].v);
        chk($sformatf("fwda%0d", c), fa[c], mfa[c]);
        chk($sformatf("fwdb%0d", c), fb[c], mfb[c]);
        chk($sformatf("scnt%0d", c), sc[c], msc[c]);
        chk($sformatf("fcnt%0d", c), fc[c], mfc[c]);
      end
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic instr(bit v, int a, bit ua, int b, bit ub,
                       int d, bit w, bit m);
    idv = v; rs1 = 5'(a); u1 = ua; rs2 = 5'(b); u2 = ub;
    rd = 5'(d); rw = w; mr = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    chk_en = 1'b0;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; br = 1'b1; busy = 1'b1;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    #1;
    chk("rst_flush", flu[0], 0);
    chk("rst_exv", exv[1], 0);
    chk("rst_fwd", fa[0], 0);
    chk("rst_scnt", sc[0], 0);
    rst_n = 1'b1; br = 1'b0; busy = 1'b0;

    // load-use with forwarding
    instr(1, 0, 0, 0, 0, 5, 1, 1); tick();
    instr(1, 5, 1, 1, 1, 6, 1, 0);
    #1; chk("lu_stall", stl[0], 1); chk("lu_bubble", bub[0], 1);
    tick();
    #1; chk("lu_release", stl[0], 0);
    tick();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("lu_fwd", fa[0], 2); chk("lu_scnt", sc[0], 1);
    tick();

    // ALU chain on x3, then x0
    do_reset();
    instr(1, 1, 1, 2, 1, 3, 1, 0); tick();
    instr(1, 3, 1, 3, 1, 4, 1, 0);
    #1; chk("alu_nostall", stl[0], 0);
    tick();
    chk("alu_fwda", fa[0], 1); chk("alu_fwdb", fb[0], 1);
    instr(1, 3, 1, 0, 0, 5, 1, 0); tick();
    chk("alu_third", fa[0], 2);
    instr(1, 1, 1, 1, 1, 0, 1, 0); tick();
    instr(1, 0, 1, 0, 1, 7, 1, 0); tick();
    chk("x0_fwda", fa[0], 0); chk("x0_fwdb", fb[0], 0);

    // flush from MEM with a coincident load-use
    do_reset();
    instr(1, 0, 0, 0, 0, 2, 1, 0); tick();
    instr(1, 0, 0, 0, 0, 5, 1, 1); tick();
    instr(1, 5, 1, 0, 0, 6, 1, 0); br = 1'b1;
    #1; chk("br_flush", flu[1], 1); chk("br_nostall", stl[1], 0);
    tick();
    br = 1'b0; instr(0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("br_exv", exv[1], 0); chk("br_memv", memv[1], 0);
    chk("br_fcnt", fc[1], 1);
    tick();

    // freeze over a pending load-use
    do_reset();
    instr(1, 0, 0, 0, 0, 5, 1, 1); tick();
    instr(1, 5, 1, 0, 0, 6, 1, 0); busy = 1'b1;
    repeat (3) begin
      #1; chk("frz_stall", stl[0], 0); chk("frz_bubble", bub[0], 0);
      chk("frz_on", frz[0], 1); chk("frz_exv", exv[0], 1);
      tick();
    end
    busy = 1'b0;
    #1; chk("frz_after", stl[0], 1);
    tick();
    chk("frz_scnt", sc[0], 1);

    // no forwarding: two-cycle stall, then saturation
    do_reset();
    instr(1, 1, 1, 2, 1, 7, 1, 0); tick();
    instr(1, 7, 1, 7, 1, 8, 1, 0);
    #1; chk("nf_s1", stl[2], 1); tick();
    #1; chk("nf_s2", stl[2], 1); tick();
    #1; chk("nf_s3", stl[2], 0); tick();
    chk("nf_fwda", fa[2], 0); chk("nf_fwdb", fb[2], 0);
    chk("nf_scnt", sc[2], 2);
    repeat (2) begin
      instr(1, 1, 1, 2, 1, 7, 1, 0); tick();
      instr(1, 7, 1, 7, 1, 8, 1, 0); repeat (3) tick();
    end
    chk("nf_sat", sc[2], 3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      instr($urandom_range(0, 7) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0);
      br   = ($urandom_range(0, 7) == 0);
      busy = ($urandom_range(0, 6) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
